fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, in the rd_clk domain. Pops WIDTH-bit words
//  through the FIFO's rd_en/rd_data/fifo_empty interface and packs PACK words into one
//  wide word. Delivers the wide word on a valid/ready stream to the next stage.
//  Provides flush of partial words and a delivered-word counter.
// PARAMETERS
//  WIDTH  16  FIFO word width
//  PACK   2   FIFO words per output word (2..8)
//  CNT_W  16  width of word_cnt
// PORTS
//  rd_clk     in   1            single clock (FIFO read clock)
//  rst_n      in   1            asynchronous reset, active-low
//  fifo_empty in   1            FIFO empty flag
//  rd_en      out  1            FIFO pop request
//  rd_data    in   WIDTH        FIFO read data, valid the cycle after an accepted rd_en
//  flush      in   1            level: emit partial word, stop popping until emitted
//  out_valid  out  1            output word valid
//  out_ready  in   1            downstream accepts when out_valid && out_ready
//  out_data   out  WIDTH*PACK   packed word; first popped word in bits [WIDTH-1:0]
//  out_words  out  $clog2(PACK+1)  number of valid FIFO words in out_data (1..PACK)
//  word_cnt   out  CNT_W        count of accepted output words, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): rd_en=0, out_valid=0, out_data=0, out_words=0, word_cnt=0,
//   acc_cnt=0, pend=0. Asserting reset mid-read discards the in-flight word (pend cleared).
//  State: acc[PACK] words, acc_cnt (0..PACK), pend (rd_en accepted last cycle), output reg.
//  Landing: if pend, rd_data is written to acc slot acc_cnt and acc_cnt increments.
//  xfer = (acc_cnt==PACK || (flush && acc_cnt>0 && !pend)) && (!out_valid || out_ready).
//  On xfer: out_data <= acc (unfilled slots zero), out_words <= acc_cnt,
//   out_valid <= 1, acc_cnt <= 0 (acc contents cleared).
//  Else if out_valid && out_ready: out_valid <= 0. out_data/out_words are held stable
//   while out_valid && !out_ready.
//  word_cnt increments by one on each out_valid && out_ready cycle.
//  Pop rule (combinational rd_en): acc_eff = xfer ? 0 : acc_cnt.
//   rd_en = !fifo_empty && !(flush && acc_cnt>0) && (acc_eff + pend < PACK).
//   pend <= rd_en.
//  Invariants:
//   - rd_en is never high while fifo_empty is high.
//   - A landing word never coincides with an xfer out of a full accumulator.
//   - acc_cnt + pend <= PACK at all times.
//  Backpressure: with out_ready=0, at most PACK*2 words are popped (output reg + acc),
//   then rd_en stays 0.
//  Flush with acc_cnt==0 is a no-op. Flush with acc_cnt==PACK is a normal transfer.
//  Throughput with PACK=2 and no backpressure: 2 words per 3 rd_clk cycles.
// TESTING
//  1 Reset: hold rst_n=0, toggle inputs -> rd_en, out_valid, word_cnt, out_data all 0.
//  2 FIFO holds 0x000A,0x0003, out_ready=1 -> out_data=0x0003000A, out_words=2,
//    out_valid high for one cycle, word_cnt=1, rd_en pulsed exactly twice.
//  3 Six words queued, out_ready=0 -> exactly 4 pops, then rd_en=0 with out_data stable.
//    Raise out_ready -> 3 output words delivered in FIFO order, word_cnt=3.
//  4 One word 0x0005 then fifo_empty=1, pulse flush -> out_data=0x00000005,
//    out_words=1. Flush again with acc_cnt=0 -> no output.
//  5 Pop issued, then rst_n pulsed low 10ns -> no out_valid from the discarded word,
//    acc_cnt=0. Reading resumes normally afterward.
//  6 CNT_W=4, 17 output words accepted -> word_cnt reads 1 (wrapped).
//    Assertion across all tests: never (rd_en && fifo_empty).

Source files
------------

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs PACK of them into one wide stream word
module fifo_rd_packer #(
  parameter int WIDTH = 16,
  parameter int PACK  = 2,
  parameter int CNT_W = 16
) (
  input  logic                       rd_clk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  output logic                       rd_en,
  input  logic [WIDTH-1:0]           rd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*PACK-1:0]      out_data,
  output logic [$clog2(PACK+1)-1:0]  out_words,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam int CW = $clog2(PACK+1);
  localparam int DW = WIDTH * PACK;
  localparam logic [CW-1:0] FULL = CW'(PACK);

  logic [DW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
  logic             pend_q;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]    out_words_q, out_words_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic          accept;
  logic          acc_full;
  logic          flush_req;
  logic          xfer;
  logic [CW-1:0] acc_eff;
  logic [CW:0]   in_flight;

  // Pop decision looks ahead: a transfer this cycle frees the whole accumulator.
  always_comb begin
    accept    = out_valid_q && out_ready;
    acc_full  = (acc_cnt_q == FULL);
    flush_req = flush && (acc_cnt_q != '0);
    xfer      = (acc_full || (flush_req && !pend_q)) && (!out_valid_q || out_ready);
    acc_eff   = xfer ? '0 : acc_cnt_q;
    in_flight = {1'b0, acc_eff} + {{CW{1'b0}}, pend_q};
    rd_en     = rst_n && !fifo_empty && !flush_req && (in_flight < (CW+1)'(PACK));
  end

  always_comb begin
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_words_d = out_words_q;
    word_cnt_d  = word_cnt_q;

    if (xfer) begin
      out_data_d  = acc_q;
      out_words_d = acc_cnt_q;
      out_valid_d = 1'b1;
      acc_d       = '0;
      acc_cnt_d   = '0;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    // A landing word never meets a transfer: xfer requires pend low or a full accumulator.
    if (pend_q && !acc_full) begin
      acc_d[int'(acc_cnt_q)*WIDTH +: WIDTH] = rd_data;
      acc_cnt_d = acc_cnt_q + CW'(1);
    end

    if (accept) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_cnt_q   <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_words_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_cnt_q   <= acc_cnt_d;
      pend_q      <= rd_en;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_words_q <= out_words_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_words = out_words_q;
  assign word_cnt  = word_cnt_q;

endmodule
